// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Package     : button_pkg
// Description : Shared hold-FSM encodings and 100 MHz board timing defaults
//               for the push-button conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_REPEAT = 2'd2
  } hold_state_t;

  localparam int unsigned C_CLK_HZ             = 100_000_000;
  localparam int unsigned C_DEBOUNCE_10MS      = C_CLK_HZ / 100;
  localparam int unsigned C_REPEAT_DELAY_250MS = C_CLK_HZ / 4;
  localparam int unsigned C_REPEAT_RATE_50MS   = C_CLK_HZ / 20;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : Single-button synchroniser, debounce, edge pulses and hold
//               auto-repeat FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic rep_en,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic press_next
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HCW = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [DCW-1:0] c_DB_MAX   = DCW'(DEBOUNCE_CYCLES);
  localparam logic [HCW-1:0] c_DLY_LAST = HCW'(REPEAT_DELAY - 1);
  localparam logic [HCW-1:0] c_RATE_LAST = HCW'(REPEAT_RATE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   w_sync;
  logic [DCW-1:0]         db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  logic                   rep_q, rep_d;
  hold_state_t            state_q, state_d;
  logic [HCW-1:0]         hcnt_q, hcnt_d;

  assign w_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    if (w_sync == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == c_DB_MAX) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DCW'(1);
    end
    press_d = level_d & ~level_q;
    rel_d   = ~level_d & level_q;
  end

  // Release has priority over a repeat falling due in the same cycle.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    rep_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_d) begin
          state_d = S_WAIT;
          hcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (rel_d) begin
          state_d = S_IDLE;
          hcnt_d  = '0;
        end else if (!rep_en) begin
          hcnt_d = '0;
        end else if (hcnt_q == c_DLY_LAST) begin
          rep_d   = 1'b1;
          hcnt_d  = '0;
          state_d = S_REPEAT;
        end else begin
          hcnt_d = hcnt_q + HCW'(1);
        end
      end
      S_REPEAT: begin
        if (rel_d) begin
          state_d = S_IDLE;
          hcnt_d  = '0;
        end else if (!rep_en) begin
          state_d = S_WAIT;
          hcnt_d  = '0;
        end else if (hcnt_q == c_RATE_LAST) begin
          rep_d  = 1'b1;
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt_q + HCW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        hcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      rep_q    <= 1'b0;
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      rep_q    <= rep_d;
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign repeat_pulse  = rep_q;
  assign press_next    = press_d;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : N-channel push-button front end with debounce, edge pulses,
//               hold auto-repeat and a combined any-press strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] rep_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic             any_press
);

  logic [N_BTN-1:0] w_press_next;
  logic             any_press_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .btn_raw       (btn_raw[i]),
      .rep_en        (rep_en[i]),
      .btn_level     (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .press_next    (w_press_next[i])
    );
  end

  // Registered from the channels' next-cycle press so it lines up with press_pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |w_press_next;
    end
  end

  assign any_press = any_press_q;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed, table-driven bench for button_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int N_BTN = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_BTN-1:0] btn_raw = '0;
  logic [N_BTN-1:0] rep_en = '0;
  logic [N_BTN-1:0] btn_level, press_pulse, release_pulse, repeat_pulse;
  logic             any_press;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN           (N_BTN),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_RATE     (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .rep_en        (rep_en),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .any_press     (any_press)
  );

  typedef struct {
    logic       rst;
    logic [1:0] raw;
    logic [1:0] en;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] rpt;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  logic [8:0] obs;

  assign obs = {btn_level, press_pulse, release_pulse, repeat_pulse, any_press};

  function automatic logic [8:0] pack(input logic [1:0] lvl, input logic [1:0] prs,
                                      input logic [1:0] rel, input logic [1:0] rpt);
    return {lvl, prs, rel, rpt, |prs};
  endfunction

  task automatic add_rows(input int n, input logic rst, input logic [1:0] raw,
                          input logic [1:0] en, input logic [1:0] lvl, input logic [1:0] prs,
                          input logic [1:0] rel, input logic [1:0] rpt);
    vec_t v;
    v.rst = rst; v.raw = raw; v.en = en;
    v.lvl = lvl; v.prs = prs; v.rel = rel; v.rpt = rpt;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got lvl/prs/rel/rpt/any=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // rst raw en | lvl prs rel rpt
    add_rows(2, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add_rows(6, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add_rows(1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
    add_rows(2, 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add_rows(6, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add_rows(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add_rows(1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // Channel 1 bounce: never stable long enough to register.
    add_rows(3, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add_rows(2, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add_rows(3, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add_rows(8, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < tbl.size(); i++) begin
      reset   = tbl[i].rst;
      btn_raw = tbl[i].raw;
      rep_en  = tbl[i].en;
      tick();
      check($sformatf("vec%0d", i), obs,
            pack(tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].rpt));
    end

    // Auto-repeat while held, then release stops repeats.
    btn_raw = 2'b01; rep_en = 2'b01;
    for (int e = 0; e <= 36; e++) begin
      int  k;
      logic r;
      k = e - 6;
      tick();
      r = (k >= 10) && (k < 24) && ((k - 10) % 3 == 0);
      check($sformatf("repeat k=%0d", k), obs,
            pack({1'b0, (e >= 6) && (k < 24)}, {1'b0, e == 6}, {1'b0, k == 24}, {1'b0, r}));
      if (k == 17) btn_raw = 2'b00;
    end

    // Repeat disabled mid-hold, then re-enabled.
    btn_raw = 2'b01; rep_en = 2'b01;
    for (int e = 0; e <= 42; e++) begin
      int  k;
      logic r;
      k = e - 6;
      tick();
      r = (k == 10) || ((k >= 25) && (k < 35) && ((k - 25) % 3 == 0));
      check($sformatf("repdis k=%0d", k), obs,
            pack({1'b0, (e >= 6) && (k < 35)}, {1'b0, e == 6}, {1'b0, k == 35}, {1'b0, r}));
      if (k == 10) rep_en = 2'b00;
      if (k == 15) rep_en = 2'b01;
      if (k == 28) btn_raw = 2'b00;
    end

    // Release lands exactly when a repeat would fall due.
    btn_raw = 2'b01; rep_en = 2'b01;
    for (int e = 0; e <= 26; e++) begin
      int k;
      k = e - 6;
      tick();
      check($sformatf("collide k=%0d", k), obs,
            pack({1'b0, (e >= 6) && (k < 13)}, {1'b0, e == 6}, {1'b0, k == 13}, {1'b0, k == 10}));
      if (k == 6) btn_raw = 2'b00;
    end

    // Reset while in REPEAT, button still held.
    btn_raw = 2'b01; rep_en = 2'b01;
    for (int e = 0; e <= 18; e++) begin
      int k;
      k = e - 6;
      tick();
      check($sformatf("prerst k=%0d", k), obs,
            pack({1'b0, e >= 6}, {1'b0, e == 6}, 2'b00, {1'b0, k == 10}));
    end
    reset = 1'b1;
    tick();
    check("reset_mid_hold", obs, 9'd0);
    reset = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      tick();
      check($sformatf("postrst j=%0d", j), obs,
            pack({1'b0, j >= 7}, {1'b0, j == 7}, 2'b00, 2'b00));
    end
    btn_raw = 2'b00;
    for (int j = 1; j <= 8; j++) begin
      tick();
      check($sformatf("postrst_rel j=%0d", j), obs,
            pack({1'b0, j < 7}, 2'b00, {1'b0, j == 7}, 2'b00));
    end

    // Simultaneous presses on both channels.
    btn_raw = 2'b11; rep_en = 2'b00;
    for (int e = 0; e <= 8; e++) begin
      tick();
      check($sformatf("both_press e=%0d", e), obs,
            pack((e >= 6) ? 2'b11 : 2'b00, (e == 6) ? 2'b11 : 2'b00, 2'b00, 2'b00));
    end
    btn_raw = 2'b00;
    for (int e = 0; e <= 8; e++) begin
      tick();
      check($sformatf("both_rel e=%0d", e), obs,
            pack((e < 6) ? 2'b11 : 2'b00, 2'b00, (e == 6) ? 2'b11 : 2'b00, 2'b00));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
